// File: rtl/subpel_block_scheduler.sv
// Block scheduler for the sub-pixel interpolation engine: raster-walks the frame's blocks,
// fetches one reference row at a time, feeds the engine and hands finished block coordinates on.
module subpel_block_scheduler #(
    parameter int unsigned BLK_COLS     = 4,
    parameter int unsigned BLK_ROWS     = 4,
    parameter int unsigned ROWS_PER_BLK = 15,
    parameter int unsigned ROW_W        = 120,
    parameter int unsigned BX_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [BX_W-1:0]  req_bx,
    output logic [BX_W-1:0]  req_by,
    output logic [3:0]       req_row,
    input  logic             rsp_valid,
    input  logic [ROW_W-1:0] rsp_row,
    output logic             eng_clr,
    output logic [ROW_W-1:0] eng_row,
    output logic             eng_row_valid,
    input  logic             eng_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BX_W-1:0]  out_bx,
    output logic [BX_W-1:0]  out_by
);
    localparam int unsigned ROW_IW = 4;
    localparam logic [ROW_IW-1:0] LAST_ROW = ROW_IW'(ROWS_PER_BLK - 1);
    localparam logic [BX_W-1:0]   LAST_BX  = BX_W'(BLK_COLS - 1);
    localparam logic [BX_W-1:0]   LAST_BY  = BX_W'(BLK_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_FEED  = 3'd4,
        S_DRAIN = 3'd5,
        S_OUT   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [BX_W-1:0]   bx_q, bx_d, by_q, by_d;
    logic [BX_W-1:0]   out_bx_q, out_bx_d, out_by_q, out_by_d;
    logic [ROW_IW-1:0] row_q, row_d;
    logic [ROW_W-1:0]  eng_row_q, eng_row_d;
    logic              err_q, err_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, req_valid_q, eng_clr_q, eng_row_valid_q, out_valid_q;
    logic              err_clr, err_set;

    // State, counters and registered outputs; strobes are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bx_q            <= '0;
            by_q            <= '0;
            row_q           <= '0;
            out_bx_q        <= '0;
            out_by_q        <= '0;
            eng_row_q       <= '0;
            err_q           <= 1'b0;
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
            req_valid_q     <= 1'b0;
            eng_clr_q       <= 1'b0;
            eng_row_valid_q <= 1'b0;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            bx_q            <= bx_d;
            by_q            <= by_d;
            row_q           <= row_d;
            out_bx_q        <= out_bx_d;
            out_by_q        <= out_by_d;
            eng_row_q       <= eng_row_d;
            err_q           <= err_d;
            frame_done_q    <= frame_done_d;
            busy_q          <= (state_d != S_IDLE);
            req_valid_q     <= (state_d == S_REQ);
            eng_clr_q       <= (state_d == S_CLR);
            eng_row_valid_q <= (state_d == S_FEED);
            out_valid_q     <= (state_d == S_OUT);
        end
    end

    // Next-state, raster counters and sticky protocol error.
    always_comb begin
        state_d      = state_q;
        bx_d         = bx_q;
        by_d         = by_q;
        row_d        = row_q;
        out_bx_d     = out_bx_q;
        out_by_d     = out_by_q;
        eng_row_d    = eng_row_q;
        frame_done_d = 1'b0;
        err_clr      = 1'b0;
        err_set      = (rsp_valid && (state_q != S_WAIT)) ||
                       (eng_done  && (state_q != S_DRAIN));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    bx_d    = '0;
                    by_d    = '0;
                    row_d   = '0;
                    err_clr = 1'b1;
                end
            end
            S_CLR: state_d = S_REQ;
            S_REQ: begin
                if (req_valid_q && req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    eng_row_d = rsp_row;
                    state_d   = S_FEED;
                end
            end
            S_FEED: begin
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    row_d   = row_q + ROW_IW'(1);
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (eng_done) begin
                    out_bx_d = bx_q;
                    out_by_d = by_q;
                    state_d  = S_OUT;
                end
            end
            S_OUT: begin
                if (out_valid_q && out_ready) begin
                    if ((bx_q == LAST_BX) && (by_q == LAST_BY)) begin
                        bx_d         = '0;
                        by_d         = '0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        if (bx_q == LAST_BX) begin
                            bx_d = '0;
                            by_d = by_q + BX_W'(1);
                        end else begin
                            bx_d = bx_q + BX_W'(1);
                        end
                        state_d = S_CLR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d = err_clr ? 1'b0 : (err_q | err_set);
    end

    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign err           = err_q;
    assign req_valid     = req_valid_q;
    assign req_bx        = bx_q;
    assign req_by        = by_q;
    assign req_row       = row_q;
    assign eng_clr       = eng_clr_q;
    assign eng_row       = eng_row_q;
    assign eng_row_valid = eng_row_valid_q;
    assign out_valid     = out_valid_q;
    assign out_bx        = out_bx_q;
    assign out_by        = out_by_q;

endmodule

// File: tb/tb_subpel_block_scheduler.sv
// Randomized bench for subpel_block_scheduler: the bench plays memory, engine and consumer
// and checks every request, strobe and result against a raster-order expectation list.
module tb_subpel_block_scheduler;
    localparam int unsigned BLK_COLS     = 3;
    localparam int unsigned BLK_ROWS     = 2;
    localparam int unsigned ROWS_PER_BLK = 15;
    localparam int unsigned ROW_W        = 120;
    localparam int unsigned BX_W         = 8;
    localparam int          NBLK         = int'(BLK_COLS * BLK_ROWS);
    localparam int          NROWS        = int'(ROWS_PER_BLK);

    logic             clk = 1'b0;
    logic             rst, start, req_ready, rsp_valid, eng_done, out_ready;
    logic [ROW_W-1:0] rsp_row;
    logic             busy, frame_done, err, req_valid, eng_clr, eng_row_valid, out_valid;
    logic [BX_W-1:0]  req_bx, req_by, out_bx, out_by;
    logic [3:0]       req_row;
    logic [ROW_W-1:0] eng_row;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    subpel_block_scheduler #(
        .BLK_COLS(BLK_COLS), .BLK_ROWS(BLK_ROWS), .ROWS_PER_BLK(ROWS_PER_BLK),
        .ROW_W(ROW_W), .BX_W(BX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done), .err(err),
        .req_valid(req_valid), .req_ready(req_ready), .req_bx(req_bx), .req_by(req_by),
        .req_row(req_row), .rsp_valid(rsp_valid), .rsp_row(rsp_row), .eng_clr(eng_clr),
        .eng_row(eng_row), .eng_row_valid(eng_row_valid), .eng_done(eng_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_bx(out_bx), .out_by(out_by)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ctl_vec();
        return 128'({busy, frame_done, err, req_valid, req_bx, req_by, req_row,
                     eng_clr, eng_row_valid, out_valid, out_bx, out_by});
    endfunction

    // rnd: random latencies and backpressure; inj: protocol errors; start_mid: start while busy;
    // rst_mid: reset during row 7 of block (1,0).
    task automatic run_frame(input bit rnd, input bit inj, input bit start_mid, input bit rst_mid);
        logic [23:0]      exp_req[$];
        logic [15:0]      exp_out[$];
        logic [ROW_W-1:0] exp_row[$];
        logic [ROW_W-1:0] rsp_data;
        logic [23:0]      cur_req, prev_req;
        logic [15:0]      cur_out, prev_out;
        int rsp_cd, done_cd, strobe_due, req_due, blk_strobes, out_left;
        int req_cnt, strobe_cnt, clr_cnt, req_stall, out_stall;
        bit req_hold, out_hold, fd_expect, finished, rst_pend, inj_rsp, inj_done;

        rsp_cd = -1; done_cd = -1; strobe_due = -1; req_due = -1; blk_strobes = 0;
        out_left = NBLK; req_cnt = 0; strobe_cnt = 0; clr_cnt = 0; req_stall = 0; out_stall = 0;
        req_hold = 1'b0; out_hold = 1'b0; fd_expect = 1'b0; finished = 1'b0;
        rst_pend = 1'b0; inj_rsp = 1'b0; inj_done = 1'b0;
        rsp_data = '0; prev_req = '0; prev_out = '0;

        // Reference order: block rows outer, block columns inner, rows within each block.
        for (int by = 0; by < int'(BLK_ROWS); by++) begin
            for (int bx = 0; bx < int'(BLK_COLS); bx++) begin
                for (int r = 0; r < NROWS; r++) exp_req.push_back({8'(bx), 8'(by), 8'(r)});
                exp_out.push_back({8'(bx), 8'(by)});
            end
        end

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("err_clr_on_start", 128'(err), 128'(0));

        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            rsp_valid = 1'b0;
            eng_done  = 1'b0;
            start     = start_mid && (cyc == 120);

            if (rst_pend) begin
                rst = 1'b0;
                check_eq("rst_mid_outputs", ctl_vec(), 128'(0));
                check_eq("rst_mid_eng_row", 128'(eng_row), 128'(0));
                finished = 1'b1;
            end else if (fd_expect) begin
                check_eq("frame_done_pulse", 128'(frame_done), 128'(1));
                check_eq("busy_after_frame", 128'(busy), 128'(0));
                finished = 1'b1;
            end else begin
                check_eq("busy_in_frame", 128'(busy), 128'(1));
                if (frame_done) check_eq("early_frame_done", 128'(frame_done), 128'(0));
                if (eng_clr) clr_cnt++;

                if (rsp_cd > 0) begin
                    rsp_cd--;
                    if (rsp_cd == 0) begin
                        rsp_valid  = 1'b1;
                        rsp_row    = rsp_data;
                        exp_row.push_back(rsp_data);
                        strobe_due = cyc + 1;
                        rsp_cd     = -1;
                    end
                end

                if (done_cd > 0) begin
                    done_cd--;
                    if (done_cd == 0) begin
                        eng_done = 1'b1;
                        done_cd  = -1;
                    end else if (inj && !inj_rsp) begin
                        rsp_valid = 1'b1;
                        rsp_row   = '1;
                        inj_rsp   = 1'b1;
                    end
                end

                if (eng_row_valid) begin
                    if (exp_row.size() == 0) check_eq("strobe_extra", 128'(1), 128'(0));
                    else check_eq("strobe_data", 128'(eng_row), 128'(exp_row.pop_front()));
                    check_eq("strobe_latency", 128'(cyc), 128'(strobe_due));
                    strobe_cnt++;
                    blk_strobes++;
                    if (blk_strobes == NROWS) begin
                        blk_strobes = 0;
                        done_cd = (rnd && !inj) ? int'($urandom_range(1, 4)) : 3;
                    end else begin
                        req_due = cyc + 1;
                    end
                end

                if (req_valid) begin
                    cur_req = {req_bx, req_by, 4'h0, req_row};
                    if (req_hold) begin
                        check_eq("req_stable", 128'(cur_req), 128'(prev_req));
                    end else begin
                        if (exp_req.size() == 0) check_eq("req_extra", 128'(1), 128'(0));
                        else check_eq("req_coord", 128'(cur_req), 128'(exp_req.pop_front()));
                        if (req_due >= 0) check_eq("req_latency", 128'(cyc), 128'(req_due));
                        req_due = -1;
                        req_cnt++;
                        if (rnd && ($urandom_range(0, 3) == 0)) req_stall = 5;
                        if (rst_mid && (cur_req == {8'd1, 8'd0, 8'd7})) begin
                            rst      = 1'b1;
                            rst_pend = 1'b1;
                        end
                        if (inj && !inj_done && (req_cnt == 20)) begin
                            eng_done = 1'b1;
                            inj_done = 1'b1;
                        end
                    end
                    req_ready = (req_stall == 0);
                    if (req_stall > 0) req_stall--;
                    req_hold = !req_ready;
                    prev_req = cur_req;
                    if (req_ready) begin
                        rsp_cd   = rnd ? int'($urandom_range(1, 3)) : 2;
                        rsp_data = ROW_W'({$urandom(), $urandom(), $urandom(), $urandom()});
                    end
                end else begin
                    if (req_hold) check_eq("req_dropped", 128'(req_valid), 128'(1));
                    req_hold  = 1'b0;
                    req_ready = 1'($urandom_range(0, 1));
                end

                if (out_valid) begin
                    cur_out = {out_bx, out_by};
                    if (out_hold) begin
                        check_eq("out_stable", 128'(cur_out), 128'(prev_out));
                    end else begin
                        if (exp_out.size() == 0) check_eq("out_extra", 128'(1), 128'(0));
                        else check_eq("out_coord", 128'(cur_out), 128'(exp_out.pop_front()));
                        if (rnd && ($urandom_range(0, 1) == 0)) out_stall = 7;
                    end
                    out_ready = (out_stall == 0);
                    if (out_stall > 0) out_stall--;
                    out_hold = !out_ready;
                    prev_out = cur_out;
                    if (out_ready) begin
                        out_left--;
                        if (out_left == 0) fd_expect = 1'b1;
                    end
                end else begin
                    if (out_hold) check_eq("out_dropped", 128'(out_valid), 128'(1));
                    out_hold  = 1'b0;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end

        rsp_valid = 1'b0; eng_done = 1'b0; start = 1'b0; rst = 1'b0;
        req_ready = 1'b0; out_ready = 1'b0;
        if (!finished) check_eq("frame_timeout", 128'(0), 128'(1));
        if (!rst_mid) begin
            check_eq("req_total", 128'(req_cnt), 128'(NBLK * NROWS));
            check_eq("strobe_total", 128'(strobe_cnt), 128'(NBLK * NROWS));
            check_eq("clr_total", 128'(clr_cnt), 128'(NBLK));
            check_eq("req_left", 128'(exp_req.size()), 128'(0));
            check_eq("out_left", 128'(exp_out.size()), 128'(0));
            repeat (4) begin
                @(negedge clk);
                check_eq("idle_quiet", 128'({busy, frame_done, req_valid, eng_clr, eng_row_valid, out_valid}),
                         128'(0));
            end
            check_eq("err_state", 128'(err), 128'(inj));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_row = '0;
        eng_done = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", ctl_vec(), 128'(0));
        check_eq("reset_eng_row", 128'(eng_row), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/subpel_block_scheduler.md
Name: subpel_block_scheduler

Overview:
- Sequences the sub-pixel interpolation engine over a frame of 8x8 blocks.
- For each block, raster-walks block positions and issues one 15-pixel reference-row request per row (15 rows). Each returned row is forwarded to the engine with a one-cycle valid strobe.
- After feeding a block, waits for the engine's completion and presents the block coordinates on an output handshake.
- Sits between the frame/reference memory and the interpolation datapath; it is the engine's only row source.

Parameters:
- BLK_COLS, 4, blocks per frame row (>=1)
- BLK_ROWS, 4, block rows per frame (>=1)
- ROWS_PER_BLK, 15, reference rows fetched per block (8 + 7 filter taps)
- ROW_W, 120, bits per reference row (15 pixels x 8 bits)
- BX_W, 8, width of block x/y coordinates

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after last block's output accepted
- err  out  1  sticky protocol error; cleared only by rst or accepted start
- req_valid  out  1  row request valid
- req_ready  in  1  memory accepts request
- req_bx  out  BX_W  block column of request
- req_by  out  BX_W  block row of request
- req_row  out  4  row index 0..ROWS_PER_BLK-1 within block
- rsp_valid  in  1  returned row valid
- rsp_row  in  ROW_W  returned row data
- eng_clr  out  1  one-cycle engine clear before each block
- eng_row  out  ROW_W  registered row to engine
- eng_row_valid  out  1  one-cycle strobe per row
- eng_done  in  1  engine finished current block
- out_valid  out  1  block result ready
- out_ready  in  1  consumer accepts
- out_bx  out  BX_W  block column of result
- out_by  out  BX_W  block row of result

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, including eng_row, coordinates and err.
  - Row and block counters 0.
  - rst mid-operation aborts immediately. No pending handshake is honoured afterwards.
- States: IDLE, CLR, REQ, WAIT, FEED, DRAIN, OUT.
- IDLE:
  - start=1 -> CLR; bx=by=row=0; err cleared.
  - start in any other state is ignored.
- CLR: eng_clr=1 for one cycle -> REQ.
- REQ:
  - req_valid=1 with req_bx/by/row stable until req_valid&&req_ready -> WAIT.
  - Only one request is outstanding at a time.
- WAIT:
  - On rsp_valid: capture rsp_row into eng_row -> FEED.
  - rsp_valid in the same cycle as the request handshake is not accepted; it is counted as a protocol error (err=1).
- FEED:
  - eng_row_valid=1 for exactly this cycle.
  - If row==ROWS_PER_BLK-1: -> DRAIN, row=0.
  - Otherwise: row+1 -> REQ.
- DRAIN: wait for eng_done -> OUT; out_bx/out_by latched from current block.
- OUT:
  - out_valid=1 with out_bx/by held until out_ready.
  - On acceptance: if bx==BLK_COLS-1 and by==BLK_ROWS-1, pulse frame_done in the next cycle and -> IDLE.
  - Otherwise advance raster: bx+1, or bx=0/by+1 on wrap. -> CLR.
- Timing:
  - Row latency: rsp_valid at cycle t -> eng_row_valid at t+1 -> next req_valid at t+2.
  - Minimum per block: 1 + 15x3 + DRAIN + OUT cycles.
- Error conditions (set err, otherwise ignore the event):
  - rsp_valid outside WAIT.
  - eng_done outside DRAIN.
- Ordering and simultaneous events:
  - eng_done in the same cycle DRAIN is entered is not seen; it must arrive on a later cycle. The engine produces eng_done at least one cycle after the last row strobe.
  - out_ready without out_valid: no effect.
- Degenerate frame: BLK_COLS=BLK_ROWS=1 processes one block, then frame_done.
- Wrap rules:
  - Counters never exceed their limits.
  - bx/by are zero-extended into BX_W.

Test Plan:
- Basic frame, BLK_COLS=2, BLK_ROWS=1, memory always ready, rsp_valid 2 cycles after request, eng_done 3 cycles after the 15th strobe, out_ready=1:
  - exactly 30 requests, row 0..14 with bx=0 then bx=1;
  - 30 eng_row_valid strobes carrying the returned data unchanged;
  - 2 eng_clr pulses;
  - out (0,0) then (1,0);
  - one frame_done; busy low afterwards.
- Backpressure: req_ready low for 5 cycles, out_ready low for 7 cycles -> req_* and out_* held stable throughout; no duplicate strobes; same totals as the basic frame.
- Protocol errors: rsp_valid pulse while in DRAIN, and eng_done pulse while in REQ -> err=1 and stays 1; sequencing unaffected; next accepted start clears err.
- Reset mid-block: assert rst during row 7 of block (1,0) -> next cycle all outputs 0, IDLE. A new start restarts at (0,0) row 0.
- Start while busy: pulse start in the middle of the frame -> ignored; counters continue; exactly one frame_done.
- Raster wrap, BLK_COLS=3, BLK_ROWS=2 -> out order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); frame_done one cycle after the last acceptance.
